cac_tsv_link_sched: RTL and testbench
=====================================

// Module: cac_tsv_link_sched
// PURPOSE
// - Shares one CAC Fibonacci coder (CACcoder_*) and its TSV bundle between two requesters.
// - Round-robin arbitration with valid/ready handshakes on both request ports.
// - Drives the coder's data input one word at a time.
// - Tracks which requester owns each in-flight word and screens coded TSV words for forbidden-transition (FTF) patterns.
// - Sits between the requesting logic and the CACcoder_N/CACdec_N pair.
// PARAMETERS
// - DW          7  data word width; equals the coder's BLEN_N input width.
// - NTSV        6  TSV lanes driven by the coder.
// - CODER_LAT   1  cycles from enc_load to a valid tsv_in; range 1..4.
// - HALT_ON_ERR 1  1 = enter HOLD on an FTF error; 0 = count the error and keep running.
// PORTS
// - clock         in   1     single system clock, rising edge.
// - reset         in   1     synchronous, active-high.
// - req0_valid    in   1     requester 0 has a word.
// - req0_data     in   DW    requester 0 word.
// - req0_ready    out  1     requester 0 word accepted this cycle.
// - req1_valid    in   1     requester 1 has a word.
// - req1_data     in   DW    requester 1 word.
// - req1_ready    out  1     requester 1 word accepted this cycle.
// - err_clear     in   1     pulse; releases HOLD.
// - enc_data      out  DW    word to the coder datain.
// - enc_load      out  1     enc_data is valid this cycle.
// - tsv_in        in   NTSV  coded word from the coder.
// - tsv_valid     out  1     registered tsv_out, src and ftf_err are valid.
// - tsv_out       out  NTSV  registered copy of the checked tsv_in.
// - tsv_src       out  1     owning requester of tsv_out.
// - ftf_err       out  1     1-cycle pulse; FTF violation in tsv_out.
// - err_count     out  16    saturating count of FTF errors.
// - hold          out  1     FSM is in HOLD.
// BEHAVIOUR
// - Reset values: all outputs 0, FSM = RUN, rr_last = 1 (so requester 0 wins first), tag pipeline empty.
// - Any cycle with reset high: everything returns to reset values immediately; in-flight words are dropped silently.
// - FSM states:
//   - RUN: arbitrate.
//   - RUN -> HOLD: tsv_valid & ftf_err & HALT_ON_ERR.
//   - HOLD: both ready signals are 0; in-flight words still drain and are checked.
//   - HOLD -> RUN: err_clear high with no new ftf_err the same cycle. If both occur together, the error wins and the FSM stays in HOLD.
// - Arbitration, RUN only:
//   - readyX is combinational from the valids, state and rr_last.
//   - Only one of req0/req1 is granted per cycle.
//   - If both are valid, grant !rr_last. rr_last updates on each accepted transfer.
//   - A lone valid is granted immediately.
//   - Valids must not depend on ready. A requester holds its data stable until accepted.
// - Issue:
//   - Transfer happens when valid & ready.
//   - On the next cycle: enc_load = 1, enc_data = accepted word.
//   - With no transfer: enc_load = 0, enc_data holds its last value.
//   - Throughput is 1 word/cycle.
// - Tag pipeline:
//   - A CODER_LAT-deep shift register of {valid, src}, loaded from enc_load.
//   - tsv_in is sampled in the cycle the pipeline's last stage is valid.
//   - tsv_out, tsv_src, tsv_valid and ftf_err register the following cycle.
//   - Accept-to-tsv_valid latency = CODER_LAT + 2 cycles.
// - FTF rule: violation if any odd index j has tsv_in[j] == 0 with a neighbour tsv_in[j-1] == 1 or tsv_in[j+1] == 1, where that neighbour exists. Example: 6'b010000 (bit 5 = 0, bit 4 = 1) is a violation.
// - err_count increments on each ftf_err and saturates at 16'hFFFF. err_clear does not clear it; only reset does.
// - Simultaneous accept while the pipeline is full is legal; stages shift every cycle, so no back-pressure is needed.
// CONFIGURATION
// - Macro CAC_LOOPBACK_CHK_EN adds:
//   - Port dec_data  in  DW, from CACdec_N, aligned with tsv_in.
//   - A DW-wide data shadow in the tag pipeline.
//   - A registered mismatch pulse alongside ftf_err when dec_data differs from the issued word.
//   - mismatch also increments err_count and triggers HOLD under the same rules as ftf_err.
// - Without CAC_LOOPBACK_CHK_EN: no dec_data port, no shadow registers, and only FTF errors are counted.
// TESTING
// 1. Reset held 3 cycles mid-stream (req0_valid = 1) -> all outputs 0, err_count = 0, no tsv_valid for 2 cycles after release.
// 2. req0 and req1 both valid continuously, data 0..9 each -> grants alternate 0,1,0,1; tsv_src alternates; 1 word/cycle; first tsv_valid 3 cycles after first accept (CODER_LAT = 1).
// 3. Coder model returns tsv 6'b010000 for one word, HALT_ON_ERR = 1 -> ftf_err for 1 cycle; err_count = 1; hold = 1; both ready = 0; remaining in-flight word still reported.
// 4. In HOLD, err_clear on the same cycle as a second ftf_err -> stays in HOLD, err_count = 2; err_clear alone next cycle -> RUN.
// 5. Force 65540 errors with HALT_ON_ERR = 0 -> err_count saturates at 16'hFFFF, arbitration never stalls.
// 6. With CAC_LOOPBACK_CHK_EN, dec_data = issued ^ 1 for one word -> mismatch pulse, err_count + 1; with dec_data = issued, no pulse.

Source files
------------

// File: rtl/cac_tsv_link_sched.sv
// Round-robin scheduler sharing one CAC coder/TSV bundle between two requesters; accept-to-tsv_valid = CODER_LAT+2; ready drops only in HOLD or reset.
// Optional CAC_LOOPBACK_CHK_EN adds dec_data_i loopback compare with a mismatch_o pulse.
module cac_tsv_link_sched #(
  parameter int DW          = 7,
  parameter int NTSV        = 6,
  parameter int CODER_LAT   = 1,
  parameter int HALT_ON_ERR = 1
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            req0_valid_i,
  input  logic [DW-1:0]   req0_data_i,
  output logic            req0_ready_o,
  input  logic            req1_valid_i,
  input  logic [DW-1:0]   req1_data_i,
  output logic            req1_ready_o,
  input  logic            err_clear_i,
  output logic [DW-1:0]   enc_data_o,
  output logic            enc_load_o,
  input  logic [NTSV-1:0] tsv_in_i,
`ifdef CAC_LOOPBACK_CHK_EN
  input  logic [DW-1:0]   dec_data_i,
  output logic            mismatch_o,
`endif
  output logic            tsv_valid_o,
  output logic [NTSV-1:0] tsv_out_o,
  output logic            tsv_src_o,
  output logic            ftf_err_o,
  output logic [15:0]     err_count_o,
  output logic            hold_o
);

  typedef enum logic {ST_RUN, ST_HOLD} state_t;

  state_t                state_q, state_d;
  logic                  rr_last_q, rr_last_d;
  logic [DW-1:0]         enc_data_q, enc_data_d;
  logic                  enc_load_q, enc_load_d;
  logic                  enc_src_q, enc_src_d;
  logic [CODER_LAT-1:0]  tag_vld_q, tag_vld_d;
  logic [CODER_LAT-1:0]  tag_src_q, tag_src_d;
  logic                  tsv_valid_q, tsv_valid_d;
  logic [NTSV-1:0]       tsv_out_q, tsv_out_d;
  logic                  tsv_src_q, tsv_src_d;
  logic                  ftf_err_q, ftf_err_d;
  logic [15:0]           err_count_q, err_count_d;
  logic                  err_evt;
  logic [1:0]            err_inc;
  logic [16:0]           err_sum;
  logic                  last_vld;
  logic                  last_src;
`ifdef CAC_LOOPBACK_CHK_EN
  logic [DW-1:0]         tag_dat_q [CODER_LAT];
  logic [DW-1:0]         tag_dat_d [CODER_LAT];
  logic                  mismatch_q, mismatch_d;
`endif

  // An odd lane at 0 may not sit next to a lane at 1; bit NTSV is a virtual 0.
  function automatic logic ftf_check(input logic [NTSV-1:0] w);
    logic [NTSV:0] wp;
    logic          v;
    wp = {1'b0, w};
    v  = 1'b0;
    for (int j = 1; j < NTSV; j += 2) begin
      if (!wp[j] && (wp[j-1] || wp[j+1])) v = 1'b1;
    end
    return v;
  endfunction

  always_comb begin
    state_d      = state_q;
    rr_last_d    = rr_last_q;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    enc_load_d   = 1'b0;
    enc_data_d   = enc_data_q;
    enc_src_d    = enc_src_q;
    if (state_q == ST_RUN && !reset_i) begin
      req0_ready_o = req0_valid_i & (~req1_valid_i | rr_last_q);
      req1_ready_o = req1_valid_i & (~req0_valid_i | ~rr_last_q);
    end
    if (req0_ready_o || req1_ready_o) begin
      enc_load_d = 1'b1;
      enc_src_d  = req1_ready_o;
      enc_data_d = req1_ready_o ? req1_data_i : req0_data_i;
      rr_last_d  = req1_ready_o;
    end
    case (state_q)
      ST_RUN:  if (err_evt && HALT_ON_ERR != 0) state_d = ST_HOLD;
      ST_HOLD: if (err_clear_i && !err_evt) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    tag_vld_d    = tag_vld_q;
    tag_src_d    = tag_src_q;
    tag_vld_d[0] = enc_load_q;
    tag_src_d[0] = enc_src_q;
    for (int i = 1; i < CODER_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_src_d[i] = tag_src_q[i-1];
    end
    last_vld    = tag_vld_q[CODER_LAT-1];
    last_src    = tag_src_q[CODER_LAT-1];
    tsv_valid_d = last_vld;
    tsv_out_d   = last_vld ? tsv_in_i : tsv_out_q;
    tsv_src_d   = last_vld ? last_src : tsv_src_q;
    ftf_err_d   = last_vld & ftf_check(tsv_in_i);
`ifdef CAC_LOOPBACK_CHK_EN
    tag_dat_d    = tag_dat_q;
    tag_dat_d[0] = enc_data_q;
    for (int i = 1; i < CODER_LAT; i++) tag_dat_d[i] = tag_dat_q[i-1];
    mismatch_d = last_vld & (dec_data_i != tag_dat_q[CODER_LAT-1]);
    err_evt    = ftf_err_q | mismatch_q;
    err_inc    = {1'b0, ftf_err_q} + {1'b0, mismatch_q};
`else
    err_evt    = ftf_err_q;
    err_inc    = {1'b0, ftf_err_q};
`endif
    err_sum     = {1'b0, err_count_q} + {15'd0, err_inc};
    err_count_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= ST_RUN;
      rr_last_q   <= 1'b1;
      enc_data_q  <= '0;
      enc_load_q  <= 1'b0;
      enc_src_q   <= 1'b0;
      tag_vld_q   <= '0;
      tag_src_q   <= '0;
      tsv_valid_q <= 1'b0;
      tsv_out_q   <= '0;
      tsv_src_q   <= 1'b0;
      ftf_err_q   <= 1'b0;
      err_count_q <= '0;
`ifdef CAC_LOOPBACK_CHK_EN
      for (int i = 0; i < CODER_LAT; i++) tag_dat_q[i] <= '0;
      mismatch_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      enc_data_q  <= enc_data_d;
      enc_load_q  <= enc_load_d;
      enc_src_q   <= enc_src_d;
      tag_vld_q   <= tag_vld_d;
      tag_src_q   <= tag_src_d;
      tsv_valid_q <= tsv_valid_d;
      tsv_out_q   <= tsv_out_d;
      tsv_src_q   <= tsv_src_d;
      ftf_err_q   <= ftf_err_d;
      err_count_q <= err_count_d;
`ifdef CAC_LOOPBACK_CHK_EN
      tag_dat_q   <= tag_dat_d;
      mismatch_q  <= mismatch_d;
`endif
    end
  end

  assign enc_data_o  = enc_data_q;
  assign enc_load_o  = enc_load_q;
  assign tsv_valid_o = tsv_valid_q;
  assign tsv_out_o   = tsv_out_q;
  assign tsv_src_o   = tsv_src_q;
  assign ftf_err_o   = ftf_err_q;
  assign err_count_o = err_count_q;
  assign hold_o      = (state_q == ST_HOLD);
`ifdef CAC_LOOPBACK_CHK_EN
  assign mismatch_o  = mismatch_q;
`endif

endmodule

// File: tb/tb_cac_tsv_link_sched.sv
// Scoreboard bench for cac_tsv_link_sched: a halting instance for directed traffic and a
// non-halting instance fed only forbidden codes for counter saturation.
module tb_cac_tsv_link_sched;
  localparam int DW = 7;
  localparam int NTSV = 6;

  typedef struct packed {
    logic            src;
    logic [NTSV-1:0] tsv;
    logic            ftf;
    logic            mm;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, err_clear;
  logic            req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0]   req0_data, req1_data, enc_data, dec_data;
  logic            enc_load, tsv_valid, tsv_src, ftf_err, hold, mismatch;
  logic [NTSV-1:0] tsv_in, tsv_out;
  logic [15:0]     err_count;

  logic            sat_run, sat_ready, sat_load, sat_valid, sat_src, sat_ftf, sat_hold, sat_mm;
  logic [DW-1:0]   sat_enc, sat_dec;
  logic [NTSV-1:0] sat_tsv, sat_tout;
  logic [15:0]     sat_cnt;
  logic            sat_r1rdy;

  cac_tsv_link_sched #(.DW(DW), .NTSV(NTSV), .CODER_LAT(1), .HALT_ON_ERR(1)) u_dut (
    .clock_i(clk), .reset_i(rst),
    .req0_valid_i(req0_valid), .req0_data_i(req0_data), .req0_ready_o(req0_ready),
    .req1_valid_i(req1_valid), .req1_data_i(req1_data), .req1_ready_o(req1_ready),
    .err_clear_i(err_clear), .enc_data_o(enc_data), .enc_load_o(enc_load), .tsv_in_i(tsv_in),
`ifdef CAC_LOOPBACK_CHK_EN
    .dec_data_i(dec_data), .mismatch_o(mismatch),
`endif
    .tsv_valid_o(tsv_valid), .tsv_out_o(tsv_out), .tsv_src_o(tsv_src), .ftf_err_o(ftf_err),
    .err_count_o(err_count), .hold_o(hold)
  );

  cac_tsv_link_sched #(.DW(DW), .NTSV(NTSV), .CODER_LAT(1), .HALT_ON_ERR(0)) u_sat (
    .clock_i(clk), .reset_i(rst),
    .req0_valid_i(sat_run), .req0_data_i(7'h2A), .req0_ready_o(sat_ready),
    .req1_valid_i(1'b0), .req1_data_i(7'h00), .req1_ready_o(sat_r1rdy),
    .err_clear_i(1'b0), .enc_data_o(sat_enc), .enc_load_o(sat_load), .tsv_in_i(sat_tsv),
`ifdef CAC_LOOPBACK_CHK_EN
    .dec_data_i(sat_dec), .mismatch_o(sat_mm),
`endif
    .tsv_valid_o(sat_valid), .tsv_out_o(sat_tout), .tsv_src_o(sat_src), .ftf_err_o(sat_ftf),
    .err_count_o(sat_cnt), .hold_o(sat_hold)
  );

`ifndef CAC_LOOPBACK_CHK_EN
  assign mismatch = 1'b0;
  assign sat_mm   = 1'b0;
`endif

  // Legal code keeps every odd lane at 1; word 7'h55 is corrupted to a forbidden pattern.
  function automatic logic [NTSV-1:0] code(input logic [DW-1:0] d);
    if (d == 7'h55) return 6'b010000;
    return {1'b1, d[2], 1'b1, d[1], 1'b1, d[0]};
  endfunction

  function automatic exp_t mk(input logic s, input logic [DW-1:0] d, input logic f, input logic m);
    exp_t e;
    e.src = s; e.tsv = code(d); e.ftf = f; e.mm = m;
    return e;
  endfunction

  // Coder/decoder models, one cycle of latency.
  always @(posedge clk) begin
    tsv_in   <= code(enc_data);
    dec_data <= (enc_data == 7'h66) ? (enc_data ^ 7'h01) : enc_data;
    sat_tsv  <= 6'b010000;
    sat_dec  <= sat_enc;
  end

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  exp_t          exp_q[$];
  exp_t          e;
  logic          sb_en = 1'b0;
  logic          lat_track = 1'b0;
  int            first_acc = -1, last_acc = -1, first_tv = -1;
  int            both_cnt = 0, sat_acc = 0, sat_stall = 0;

  // Requester drivers: present queue heads, hold until accepted.
  initial begin
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
    forever begin
      @(posedge clk); #1;
      req0_valid = q0.size() > 0;
      req0_data  = (q0.size() > 0) ? q0[0] : '0;
      req1_valid = q1.size() > 0;
      req1_data  = (q1.size() > 0) ? q1[0] : '0;
    end
  end

  // Monitor: accept tracking and scoreboard compare.
  always @(negedge clk) begin
    if (req0_ready && req1_ready) both_cnt++;
    if (req0_valid && req0_ready) begin
      void'(q0.pop_front());
      if (lat_track && first_acc < 0) first_acc = cyc;
      if (lat_track) last_acc = cyc;
    end
    if (req1_valid && req1_ready) begin
      void'(q1.pop_front());
      if (lat_track && first_acc < 0) first_acc = cyc;
      if (lat_track) last_acc = cyc;
    end
    if (sat_run) begin
      if (sat_ready) sat_acc++;
      else sat_stall++;
    end
    if (sb_en && !rst && tsv_valid) begin
      if (lat_track && first_tv < 0) first_tv = cyc;
      if (exp_q.size() == 0) chk("unexpected_tsv_valid", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("tsv_src", {31'd0, tsv_src}, {31'd0, e.src});
        chk("tsv_out", {26'd0, tsv_out}, {26'd0, e.tsv});
        chk("ftf_err", {31'd0, ftf_err}, {31'd0, e.ftf});
`ifdef CAC_LOOPBACK_CHK_EN
        chk("mismatch", {31'd0, mismatch}, {31'd0, e.mm});
`endif
      end
    end
  end

  task automatic drain(input string name);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0) && n < 200) begin
      @(negedge clk); n++;
    end
    repeat (2) @(negedge clk);
    chk(name, q0.size() + q1.size() + exp_q.size(), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; err_clear = 1'b0; sat_run = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {enc_load, enc_data, tsv_valid, tsv_out, tsv_src, ftf_err, hold, req0_ready, req1_ready}, 32'd0);
    chk("reset_err_count", {16'd0, err_count}, 32'd0);

    // Reset asserted for 3 cycles while requester 0 streams.
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 7; i++) q0.push_back(7'(8'h10 + i));
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_reset_ready0", {31'd0, req0_ready}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("mid_reset_outs", {enc_load, enc_data, tsv_valid, tsv_out, tsv_src, ftf_err, hold, req0_ready, req1_ready}, 32'd0);
      chk("mid_reset_err_count", {16'd0, err_count}, 32'd0);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("post_reset_no_tsv_valid", {31'd0, tsv_valid}, 32'd0);
    end
    n = 0;
    while (q0.size() > 0 && n < 50) begin @(negedge clk); n++; end
    chk("reset_stream_drained", q0.size(), 32'd0);
    repeat (6) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; sb_en = 1'b1; sat_run = 1'b1;

    // Both requesters valid continuously: strict alternation starting with requester 0.
    @(negedge clk);
    lat_track = 1'b1;
    for (int i = 0; i < 10; i++) begin
      q0.push_back(7'(i)); q1.push_back(7'(i));
      exp_q.push_back(mk(1'b0, 7'(i), 1'b0, 1'b0));
      exp_q.push_back(mk(1'b1, 7'(i), 1'b0, 1'b0));
    end
    drain("rr_drain");
    lat_track = 1'b0;
    chk("accept_to_tsv_valid_latency", first_tv - first_acc, 32'd3);
    chk("throughput_20_words", last_acc - first_acc, 32'd19);
    chk("single_grant", both_cnt, 32'd0);

    // Forbidden code halts; a second error collides with err_clear.
    @(negedge clk);
    q0.push_back(7'h01); exp_q.push_back(mk(1'b0, 7'h01, 1'b0, 1'b0));
    q0.push_back(7'h55); exp_q.push_back(mk(1'b0, 7'h55, 1'b1, 1'b0));
    q0.push_back(7'h02); exp_q.push_back(mk(1'b0, 7'h02, 1'b0, 1'b0));
    q0.push_back(7'h55); exp_q.push_back(mk(1'b0, 7'h55, 1'b1, 1'b0));
    q0.push_back(7'h04); exp_q.push_back(mk(1'b0, 7'h04, 1'b0, 1'b0));
    q0.push_back(7'h05); exp_q.push_back(mk(1'b0, 7'h05, 1'b0, 1'b0));
    q0.push_back(7'h06); exp_q.push_back(mk(1'b0, 7'h06, 1'b0, 1'b0));
    n = 0;
    do begin @(negedge clk); n++; end while (!ftf_err && n < 50);
    chk("first_ftf_seen", {31'd0, ftf_err}, 32'd1);
    @(negedge clk);
    chk("ftf_one_cycle", {31'd0, ftf_err}, 32'd0);
    chk("hold_after_err", {31'd0, hold}, 32'd1);
    chk("err_count_1", {16'd0, err_count}, 32'd1);
    chk("ready_in_hold", {30'd0, req0_ready, req1_ready}, 32'd0);
    chk("words_pending_in_hold", q0.size(), 32'd2);
    @(posedge clk); #1 err_clear = 1'b1;
    @(negedge clk);
    chk("second_ftf_with_clear", {31'd0, ftf_err}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_err_beats_clear", {31'd0, hold}, 32'd1);
    chk("err_count_2", {16'd0, err_count}, 32'd2);
    @(posedge clk); #1 err_clear = 1'b0;
    @(negedge clk);
    chk("run_after_clear", {31'd0, hold}, 32'd0);
    chk("ready_after_clear", {31'd0, req0_ready}, 32'd1);
    drain("hold_drain");

`ifdef CAC_LOOPBACK_CHK_EN
    @(negedge clk);
    q0.push_back(7'h66); exp_q.push_back(mk(1'b0, 7'h66, 1'b0, 1'b1));
    q0.push_back(7'h07); exp_q.push_back(mk(1'b0, 7'h07, 1'b0, 1'b0));
    drain("loopback_drain");
    chk("loopback_err_count", {16'd0, err_count}, 32'd3);
    chk("loopback_hold", {31'd0, hold}, 32'd1);
    @(posedge clk); #1 err_clear = 1'b1;
    @(posedge clk); #1 err_clear = 1'b0;
    @(negedge clk);
    chk("loopback_release", {31'd0, hold}, 32'd0);
`endif

    // Non-halting instance sees a forbidden code on every word.
    n = 0;
    while (sat_acc < 65545 && n < 70000) begin @(negedge clk); n++; end
    chk("sat_accepts_reached", {31'd0, sat_acc >= 65545}, 32'd1);
    repeat (4) @(negedge clk);
    chk("sat_err_count", {16'd0, sat_cnt}, 32'h0000FFFF);
    chk("sat_no_stall", sat_stall, 32'd0);
    chk("sat_no_hold", {31'd0, sat_hold}, 32'd0);
    chk("sat_ftf_pulsing", {31'd0, sat_ftf}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(1500000);
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
